// File: rtl/rr_mem_arbiter.sv
// rtl/rr_mem_arbiter.sv - round-robin arbitrated shared word memory with pipelined split reads
module rr_mem_arbiter #(
    parameter int REQUESTERS = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 256,
    parameter int RD_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] w_addr,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] w_data,
    input  logic [REQUESTERS-1:0]            w_valid,
    output logic [REQUESTERS-1:0]            w_ready,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] r_addr,
    input  logic [REQUESTERS-1:0]            r_avalid,
    output logic [REQUESTERS-1:0]            r_aready,
    output logic [REQUESTERS-1:0]            r_dvalid,
    output logic [REQUESTERS*DATA_WIDTH-1:0] r_data
);

    localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [PW-1:0]                   p_q, p_d;
    logic [REQUESTERS-1:0]           req;
    logic                            gnt_vld;
    logic [PW-1:0]                   gnt_id;
    int                              cand;
    logic                            wr_go, rd_go;
    logic [IW-1:0]                   w_idx, r_idx;
    logic [DATA_WIDTH-1:0]           w_word;
    logic [DATA_WIDTH-1:0]           mem_q [MEM_DEPTH];

    logic [RD_LATENCY-1:0]           pipe_vld_q, pipe_vld_d;
    logic [PW-1:0]                   pipe_id_q  [RD_LATENCY];
    logic [PW-1:0]                   pipe_id_d  [RD_LATENCY];
    logic [DATA_WIDTH-1:0]           pipe_dat_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0]           pipe_dat_d [RD_LATENCY];
    logic [REQUESTERS*DATA_WIDTH-1:0] r_data_q, r_data_d;

    // Round-robin search: first requesting client at or after the pointer, wrapping
    always_comb begin
        req     = w_valid | r_avalid;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = 0;
        for (int i = 0; i < REQUESTERS; i++) begin
            cand = int'(p_q) + i;
            if (cand >= REQUESTERS) begin
                cand = cand - REQUESTERS;
            end
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_id  = PW'(cand);
            end
        end
    end

    // Handshakes for the granted client (write wins over read), operand selection, pointer advance
    always_comb begin
        wr_go    = gnt_vld & w_valid[gnt_id];
        rd_go    = gnt_vld & ~w_valid[gnt_id] & r_avalid[gnt_id];
        w_ready  = '0;
        r_aready = '0;
        if (wr_go) begin
            w_ready[gnt_id] = 1'b1;
        end
        if (rd_go) begin
            r_aready[gnt_id] = 1'b1;
        end
        w_idx  = w_addr[gnt_id*ADDR_WIDTH +: IW];
        r_idx  = r_addr[gnt_id*ADDR_WIDTH +: IW];
        w_word = w_data[gnt_id*DATA_WIDTH +: DATA_WIDTH];
        p_d    = p_q;
        if (gnt_vld) begin
            p_d = (gnt_id == PW'(REQUESTERS - 1)) ? '0 : gnt_id + PW'(1);
        end
    end

    // Read pipeline: memory sampled at acceptance, then shifted; the last stage loads the client's r_data
    always_comb begin
        pipe_vld_d[0] = rd_go;
        pipe_id_d[0]  = gnt_id;
        pipe_dat_d[0] = mem_q[r_idx];
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
            pipe_dat_d[i] = pipe_dat_q[i-1];
        end
        r_data_d = r_data_q;
        if (pipe_vld_d[RD_LATENCY-1]) begin
            r_data_d[pipe_id_d[RD_LATENCY-1]*DATA_WIDTH +: DATA_WIDTH] = pipe_dat_d[RD_LATENCY-1];
        end
    end

    // Response strobe decoded from the registered last pipeline stage
    always_comb begin
        r_dvalid = '0;
        if (pipe_vld_q[RD_LATENCY-1]) begin
            r_dvalid[pipe_id_q[RD_LATENCY-1]] = 1'b1;
        end
        r_data = r_data_q;
    end

    // Arbiter pointer, read pipeline and response data registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q        <= '0;
            pipe_vld_q <= '0;
            r_data_q   <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_id_q[i]  <= '0;
                pipe_dat_q[i] <= '0;
            end
        end else begin
            p_q        <= p_d;
            pipe_vld_q <= pipe_vld_d;
            r_data_q   <= r_data_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_id_q[i]  <= pipe_id_d[i];
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
        end
    end

    // Memory array write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem_q[w_idx] <= w_word;
        end
    end

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// tb/tb_rr_mem_arbiter.sv - directed scoreboard bench for rr_mem_arbiter
module tb_rr_mem_arbiter;

    localparam int R  = 3;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int L  = 2;

    logic            clk;
    logic            reset_n;
    logic [R*AW-1:0] w_addr, r_addr;
    logic [R*DW-1:0] w_data, r_data;
    logic [R-1:0]    w_valid, w_ready, r_avalid, r_aready, r_dvalid;

    rr_mem_arbiter #(
        .REQUESTERS(R), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(256), .RD_LATENCY(L)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .r_addr(r_addr), .r_avalid(r_avalid), .r_aready(r_aready),
        .r_dvalid(r_dvalid), .r_data(r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          gnt_log[$];
    logic [15:0] model [256];
    int          n_cmp;
    int          n_bad;
    int          cyc;
    logic [R-1:0] last_w_ready, last_r_aready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sampled at negedge: protocol legality, reference model update, scoreboard push/pop
    task automatic monitor();
        exp_t e;
        last_w_ready  = w_ready;
        last_r_aready = r_aready;
        if (!reset_n) begin
            sb.delete();
            chk("rst_dvalid", 64'(r_dvalid), 64'(0));
            chk("rst_rdata", 64'(r_data), 64'(0));
            return;
        end
        chk("ready_without_valid", 64'((w_ready & ~w_valid) | (r_aready & ~r_avalid)), 64'(0));
        chk("ready_onehot", 64'($onehot0(w_ready | r_aready)), 64'(1));
        for (int k = 0; k < R; k++) begin
            if (r_dvalid[k]) begin
                if (sb.size() == 0) begin
                    chk("dvalid_unexpected", 64'(r_dvalid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rd_id", 64'(k), 64'(e.id));
                    chk("rd_data", 64'(r_data[k*DW +: DW]), 64'(e.data));
                    chk("rd_latency", 64'(cyc), 64'(e.due));
                end
            end
        end
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("rd_missing", 64'(r_dvalid), 64'(1) << sb[0].id);
            void'(sb.pop_front());
        end
        for (int k = 0; k < R; k++) begin
            if (w_ready[k]) begin
                gnt_log.push_back(k);
                model[w_addr[k*AW +: 8]] = w_data[k*DW +: DW];
            end
            if (r_aready[k]) begin
                gnt_log.push_back(k);
                sb.push_back('{id: k, data: model[r_addr[k*AW +: 8]], due: cyc + L});
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_write(input int k, input logic [15:0] a, input logic [15:0] d);
        bit got;
        got = 1'b0;
        w_valid[k] = 1'b1;
        w_addr[k*AW +: AW] = a;
        w_data[k*DW +: DW] = d;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = last_w_ready[k];
        end
        w_valid[k] = 1'b0;
        chk("write_accepted", 64'(got), 64'(1));
    endtask

    task automatic do_read(input int k, input logic [15:0] a);
        bit got;
        got = 1'b0;
        r_avalid[k] = 1'b1;
        r_addr[k*AW +: AW] = a;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = last_r_aready[k];
        end
        r_avalid[k] = 1'b0;
        chk("read_accepted", 64'(got), 64'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            cycle();
        end
        cycle();
        chk("drain", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int cnt [R];
        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        reset_n  = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        w_valid  = '0;
        r_addr   = '0;
        r_avalid = '0;
        repeat (3) cycle();
        reset_n = 1'b1;

        // Fairness: three saturated writers straight out of reset
        gnt_log.delete();
        for (int k = 0; k < R; k++) begin
            w_addr[k*AW +: AW] = 16'h0020 + 16'(k);
            w_data[k*DW +: DW] = 16'h1000 + 16'(k);
            cnt[k] = 0;
        end
        w_valid = '1;
        repeat (9) cycle();
        w_valid = '0;
        chk("fair_count", 64'(gnt_log.size()), 64'(9));
        for (int i = 0; i < 9 && i < gnt_log.size(); i++) begin
            chk("fair_order", 64'(gnt_log[i]), 64'(i % 3));
            cnt[gnt_log[i]]++;
        end
        for (int k = 0; k < R; k++) begin
            chk("fair_per_client", 64'(cnt[k]), 64'(3));
        end

        // Single write then read
        do_write(0, 16'h0010, 16'hA5A5);
        do_read(0, 16'h0010);
        drain();
        chk("single_rdata", 64'(r_data[0*DW +: DW]), 64'h A5A5);

        // Write beats read within one client
        do_write(1, 16'h0003, 16'h0000);
        w_addr[1*AW +: AW] = 16'h0003;
        r_addr[1*AW +: AW] = 16'h0003;
        w_data[1*DW +: DW] = 16'h1234;
        w_valid[1]  = 1'b1;
        r_avalid[1] = 1'b1;
        cycle();
        chk("wor_wready", 64'(last_w_ready), 64'(3'b010));
        chk("wor_raready", 64'(last_r_aready), 64'(0));
        w_valid[1] = 1'b0;
        do_read(1, 16'h0003);
        drain();
        chk("wor_rdata", 64'(r_data[1*DW +: DW]), 64'h1234);

        // Address aliasing modulo depth
        do_write(0, 16'h0105, 16'hBEEF);
        do_read(0, 16'h0005);
        drain();
        chk("alias_rdata", 64'(r_data[0*DW +: DW]), 64'hBEEF);

        // Back-to-back reads from one client
        for (int a = 0; a < 4; a++) begin
            do_write(2, 16'(a), 16'hC000 + 16'(a * 16'h0011));
        end
        r_avalid[2] = 1'b1;
        for (int a = 0; a < 4; a++) begin
            r_addr[2*AW +: AW] = 16'(a);
            cycle();
            chk("b2b_aready", 64'(last_r_aready), 64'(3'b100));
        end
        r_avalid[2] = 1'b0;
        drain();
        chk("b2b_hold", 64'(r_data[2*DW +: DW]), 64'hC033);

        // Reset while a read is in flight
        do_read(1, 16'h0010);
        reset_n = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b1;
        repeat (4) cycle();
        chk("rst_rdata_after", 64'(r_data), 64'(0));
        w_valid = '1;
        cycle();
        chk("rst_pointer", 64'(last_w_ready), 64'(3'b001));
        w_valid = '0;
        repeat (3) cycle();
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
